// File: rtl/io_port_ctrl_pkg.sv
// Register map, KSTAT layout and keypad helpers shared by the IO port controller.
// Pure declarations; no timing or flow-control behaviour.
package io_port_ctrl_pkg;

  localparam logic [7:0] IO_BASE_DFLT = 8'hF0;

  localparam logic [1:0] OFF_LED   = 2'd0;
  localparam logic [1:0] OFF_DISP  = 2'd1;
  localparam logic [1:0] OFF_KSTAT = 2'd2;
  localparam logic [1:0] OFF_KDATA = 2'd3;

  localparam int KSTAT_NE_BIT  = 0;
  localparam int KSTAT_CNT_LSB = 1;
  localparam int KSTAT_OVF_BIT = 4;

  localparam int KEY_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  typedef struct packed {
    logic             vld;
    logic [KEY_W-1:0] code;
  } key_evt_t;

  // Scan downwards so the lowest-index edge is the one that survives.
  function automatic key_evt_t first_edge(input logic [15:0] rise);
    key_evt_t evt;
    evt = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rise[i]) begin
        evt.vld  = 1'b1;
        evt.code = KEY_W'(i);
      end
    end
    return evt;
  endfunction

endpackage

// File: rtl/io_port_ctrl_key_fifo.sv
// 4-deep x 4-bit key-code FIFO; head visible combinationally, push/pop on the clock edge.
// A push into a full FIFO is dropped unless a pop happens in the same cycle; a pop when empty is ignored.
module key_fifo
  import io_port_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped LED/display/keypad port: LED, DISP, KSTAT and KDATA at IO_BASE..IO_BASE+3.
// Reads are combinational; writes and KDATA pops take effect at the clock edge; key overflow drops codes.
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int                WORD_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DFLT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] io_addr_i,
  input  logic [WORD_W-1:0] io_data_i,
  input  logic              io_we_i,
  input  logic              io_re_i,
  output logic [WORD_W-1:0] io_data_o,
  output logic              io_sel_o,
  input  logic [16:1]       keys_i,
  output logic [15:0]       led_out_o,
  output logic [WORD_W-1:0] digit_out_o,
  output logic              irq_o
);

  logic [ADDR_W-1:0] addr_diff;
  logic [1:0]        reg_off;
  logic [15:0]       led_r;
  logic [WORD_W-1:0] digit_r;
  logic              ovf_r;
  logic [16:1]       key_hist;
  logic [15:0]       rise;
  key_evt_t          evt;
  logic              multi_edge;
  logic              pop_req;
  logic [KEY_W-1:0]  fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovf_set;
  logic              wr_hit;
  logic [WORD_W-1:0] kstat_v;

  // Offset relative to the base, so the window need not be 4-aligned.
  assign addr_diff = io_addr_i - IO_BASE;
  assign reg_off   = addr_diff[1:0];
  assign io_sel_o  = (addr_diff[ADDR_W-1:2] == '0);

  assign wr_hit  = io_sel_o & io_we_i;
  assign pop_req = io_sel_o & io_re_i & ~io_we_i & (reg_off == OFF_KDATA);

  assign rise       = keys_i & ~key_hist;
  assign evt        = first_edge(rise);
  assign multi_edge = (rise & (rise - 16'd1)) != '0;
  assign ovf_set    = multi_edge | (evt.vld & fifo_full & ~pop_req);

  key_fifo u_key_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt.vld),
    .pop   (pop_req),
    .din   (evt.code),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r    <= '0;
      digit_r  <= '0;
      ovf_r    <= 1'b0;
      key_hist <= '1;
    end else begin
      key_hist <= keys_i;
      if (wr_hit && reg_off == OFF_LED)  led_r   <= io_data_i[15:0];
      if (wr_hit && reg_off == OFF_DISP) digit_r <= io_data_i;
      // A fresh overflow in the same cycle as a clear wins so no event is lost.
      if (ovf_set)
        ovf_r <= 1'b1;
      else if (wr_hit && reg_off == OFF_KSTAT && io_data_i[KSTAT_OVF_BIT])
        ovf_r <= 1'b0;
    end
  end

  always_comb begin
    kstat_v = '0;
    kstat_v[KSTAT_NE_BIT]               = ~fifo_empty;
    kstat_v[KSTAT_CNT_LSB +: CNT_W]     = fifo_count;
    kstat_v[KSTAT_OVF_BIT]              = ovf_r;
  end

  always_comb begin
    io_data_o = '0;
    if (io_sel_o) begin
      case (reg_off)
        OFF_LED:   io_data_o = WORD_W'(led_r);
        OFF_DISP:  io_data_o = digit_r;
        OFF_KSTAT: io_data_o = kstat_v;
        default:   io_data_o = WORD_W'(fifo_dout);
      endcase
    end
  end

  assign led_out_o   = led_r;
  assign digit_out_o = digit_r;
  assign irq_o       = ~fifo_empty;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: register access, key edge queueing, overflow and reset behaviour.
module tb_io_port_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  io_addr_i;
  logic [15:0] io_data_i;
  logic        io_we_i;
  logic        io_re_i;
  logic [15:0] io_data_o;
  logic        io_sel_o;
  logic [16:1] keys_i;
  logic [15:0] led_out_o;
  logic [15:0] digit_out_o;
  logic        irq_o;

  int n_cmp;
  int n_bad;

  io_port_ctrl #(.WORD_W(16), .ADDR_W(8), .IO_BASE(8'hF0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_addr_i   (io_addr_i),
    .io_data_i   (io_data_i),
    .io_we_i     (io_we_i),
    .io_re_i     (io_re_i),
    .io_data_o   (io_data_o),
    .io_sel_o    (io_sel_o),
    .keys_i      (keys_i),
    .led_out_o   (led_out_o),
    .digit_out_o (digit_out_o),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_addr_i = addr;
    io_data_i = data;
    io_we_i   = 1'b1;
    @(posedge clk);
    #1 io_we_i = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [7:0] addr, input logic [15:0] exp_v);
    @(negedge clk);
    io_addr_i = addr;
    io_re_i   = 1'b1;
    #1 chk(tag, 32'(io_data_o), 32'(exp_v));
    @(posedge clk);
    #1 io_re_i = 1'b0;
  endtask

  task automatic press(input int k);
    @(negedge clk);
    keys_i[k] = 1'b1;
    @(negedge clk);
    keys_i[k] = 1'b0;
  endtask

  // Press key k in the same cycle as a KDATA read.
  task automatic press_while_pop(input string tag, input int k, input logic [15:0] exp_v);
    @(negedge clk);
    keys_i[k] = 1'b1;
    io_addr_i = 8'hF3;
    io_re_i   = 1'b1;
    #1 chk(tag, 32'(io_data_o), 32'(exp_v));
    @(posedge clk);
    #1 io_re_i = 1'b0;
    @(negedge clk);
    keys_i[k] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    io_addr_i = '0;
    io_data_i = '0;
    io_we_i   = 1'b0;
    io_re_i   = 1'b0;
    keys_i    = '0;
    rst_n     = 1'b0;
    #1;
    chk("rst_led",   32'(led_out_o),   32'h0);
    chk("rst_digit", 32'(digit_out_o), 32'h0);
    chk("rst_irq",   32'(irq_o),       32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Register write/read
    bus_write(8'hF0, 16'hA5C3);
    chk("led_out", 32'(led_out_o), 32'hA5C3);
    bus_read("rd_led", 8'hF0, 16'hA5C3);
    bus_write(8'hF1, 16'h1234);
    chk("digit_out", 32'(digit_out_o), 32'h1234);
    bus_read("rd_disp", 8'hF1, 16'h1234);
    @(negedge clk);
    io_addr_i = 8'hF4;
    #1;
    chk("sel_f4",  32'(io_sel_o),  32'h0);
    chk("data_f4", 32'(io_data_o), 32'h0);
    io_addr_i = 8'hEF;
    #1;
    chk("sel_ef",  32'(io_sel_o),  32'h0);
    bus_read("kstat_init", 8'hF2, 16'h0000);

    // Single key
    press(5);
    bus_read("kstat_one", 8'hF2, 16'h0003);
    chk("irq_set", 32'(irq_o), 32'h1);
    bus_read("kdata_k5", 8'hF3, 16'h0004);
    chk("irq_clr", 32'(irq_o), 32'h0);
    bus_read("kstat_after", 8'hF2, 16'h0000);
    bus_read("kdata_empty", 8'hF3, 16'h0000);
    bus_read("kstat_empty_pop", 8'hF2, 16'h0000);

    // Overflow on fifth key
    for (int k = 1; k <= 5; k++) press(k);
    bus_read("kstat_ovf", 8'hF2, 16'h0019);
    bus_read("kdata_ovf0", 8'hF3, 16'h0000);
    bus_read("kdata_ovf1", 8'hF3, 16'h0001);
    bus_read("kdata_ovf2", 8'hF3, 16'h0002);
    bus_read("kdata_ovf3", 8'hF3, 16'h0003);
    bus_read("kstat_ovf_only", 8'hF2, 16'h0010);
    bus_write(8'hF2, 16'h000F);
    bus_read("kstat_w0_keep", 8'hF2, 16'h0010);
    bus_write(8'hF2, 16'h0010);
    bus_read("kstat_w1c", 8'hF2, 16'h0000);

    // Simultaneous edges: keys 3 and 9
    @(negedge clk);
    keys_i[3] = 1'b1;
    keys_i[9] = 1'b1;
    @(negedge clk);
    keys_i = '0;
    bus_read("kstat_simul", 8'hF2, 16'h0013);
    bus_read("kdata_simul", 8'hF3, 16'h0002);
    bus_read("kstat_simul_pop", 8'hF2, 16'h0010);
    bus_write(8'hF2, 16'h0010);

    // Full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) press(k);
    bus_read("kstat_full", 8'hF2, 16'h0009);
    press_while_pop("kdata_full_pp", 10, 16'h0000);
    bus_read("kstat_full_pp", 8'hF2, 16'h0009);
    bus_read("kdata_fp1", 8'hF3, 16'h0001);
    bus_read("kdata_fp2", 8'hF3, 16'h0002);
    bus_read("kdata_fp3", 8'hF3, 16'h0003);
    bus_read("kdata_fp9", 8'hF3, 16'h0009);

    // Empty FIFO with simultaneous push and pop
    press_while_pop("kdata_empty_pp", 12, 16'h0000);
    bus_read("kstat_empty_pp", 8'hF2, 16'h0003);
    bus_read("kdata_empty_pp2", 8'hF3, 16'h000B);

    // Key held through reset
    bus_write(8'hF0, 16'h00FF);
    @(negedge clk);
    keys_i[7] = 1'b1;
    @(negedge clk);
    bus_read("kdata_pre_rst", 8'hF3, 16'h0006);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_led", 32'(led_out_o), 32'h0);
    chk("rst2_digit", 32'(digit_out_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read("kstat_held", 8'hF2, 16'h0000);
    chk("irq_held", 32'(irq_o), 32'h0);
    @(negedge clk);
    keys_i[7] = 1'b0;
    press(7);
    bus_read("kstat_repress", 8'hF2, 16'h0003);
    bus_read("kdata_repress", 8'hF3, 16'h0006);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
